// File: rtl/sr_cmd_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sr_cmd_gen
//
// Turns two bouncy push-buttons into clean one-cycle set/reset commands for a
// downstream SR flip-flop.
//
// Each button goes through its own path:
//   2-flop synchronizer -> counter debouncer -> registered rising-edge detector.
//
// The two detected presses feed a small command FSM:
//   IDLE  -> SET_P (one cycle) -> HOLD (HOLD_CYCLES cycles) -> IDLE
//   IDLE  -> CLR_P (one cycle) -> HOLD (HOLD_CYCLES cycles) -> IDLE
// Simultaneous presses in IDLE are refused and flagged for one cycle.
// Presses that arrive while the FSM is busy are dropped, not queued.
//
// Parameters
//   DB_CYCLES   : consecutive stable synchronized cycles needed to accept a
//                 button level change (1..255)
//   HOLD_CYCLES : idle gap after each command pulse (1..255)
//
// Ports
//   clk      in   single clock, all state changes on its rising edge
//   reset    in   asynchronous, active-low reset
//   set_btn  in   raw set push-button (asynchronous, bouncy)
//   clr_btn  in   raw clear push-button (asynchronous, bouncy)
//   S        out  one-cycle set command
//   R        out  one-cycle reset command
//   busy     out  high while the FSM is not in IDLE
//   conflict out  one-cycle flag: set and clear qualified in the same cycle
//
// Latency: a button held high is first sampled at edge 1; synchronized after
// edge 2, debounced level rises after edge DB_CYCLES+2, the registered press
// pulse after edge DB_CYCLES+3, and the FSM enters SET_P/CLR_P at edge
// DB_CYCLES+4.
// -----------------------------------------------------------------------------
module sr_cmd_gen #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    // Channel 0 is the set button, channel 1 the clear button.
    localparam int NCH = 2;
    localparam int CW  = 8;

    // Counter values at which the last cycle of a count is reached.
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [NCH-1:0] btn_raw;
    logic [NCH-1:0] press;

    assign btn_raw = {clr_btn, set_btn};

    // -------------------------------------------------------------------------
    // Per-button input conditioning
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          level_next;
            logic          prev_reg;
            logic          press_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            // Debouncer: count consecutive cycles where the synchronized input
            // disagrees with the accepted level. Any agreeing cycle restarts the
            // count, so only an uninterrupted run of DB_CYCLES flips the level.
            always_comb begin
                cnt_next   = '0;
                level_next = level_reg;
                if (sync2_reg != level_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        level_next = ~level_reg;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    level_reg <= level_next;
                    cnt_reg   <= cnt_next;
                    // Rising edge of the debounced level against its own
                    // delayed copy; the pulse itself is registered so the FSM
                    // sees a clean one-cycle strobe. Releases are ignored.
                    prev_reg  <= level_reg;
                    press_reg <= level_reg & ~prev_reg;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Command FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] hold_cnt_reg;
    logic [CW-1:0] hold_cnt_next;
    logic          conflict_reg;
    logic          conflict_next;
    logic          set_press;
    logic          clr_press;

    assign set_press = press[0];
    assign clr_press = press[1];

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = '0;
        conflict_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // Both buttons at once is ambiguous: issue nothing, raise flag.
                if (set_press && clr_press) begin
                    conflict_next = 1'b1;
                end else if (set_press) begin
                    state_next = SET_P;
                end else if (clr_press) begin
                    state_next = CLR_P;
                end
            end
            SET_P: state_next = HOLD;
            CLR_P: state_next = HOLD;
            HOLD: begin
                // Presses seen here are simply not looked at, so they are lost.
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            conflict_reg <= conflict_next;
        end
    end

    // Outputs are decoded from registered state only, so reset forces them low
    // at once and S/R are mutually exclusive by construction.
    assign S        = (state_reg == SET_P);
    assign R        = (state_reg == CLR_P);
    assign busy     = (state_reg != IDLE);
    assign conflict = conflict_reg;

endmodule
